// File: rtl/fp_nr_mul_pipe.sv
// Last Newton-Raphson stage for inverse square root: y_next = corr * y (float31, implicit positive sign).
// Three registered stages (unpack, multiply, normalize/round/pack); x/2 rides alongside for the next iteration.
module fp_nr_mul_pipe #(
    parameter int EXP_BIAS       = 127,
    parameter bit ZERO_ON_DENORM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [30:0] corr_in,
    input  logic [30:0] y_in,
    input  logic [30:0] xh_in,
    output logic [30:0] float_out,
    output logic [30:0] float_out_delay,
    output logic        ready
);

    // Stage 1 registers
    logic               r_v1;
    logic [23:0]        r_mc1;
    logic [23:0]        r_my1;
    logic signed [9:0]  r_e1;
    logic               r_z1;
    logic [30:0]        r_xh1;

    // Stage 2 registers (only product bits from the guard position upward are kept)
    logic               r_v2;
    logic [25:0]        r_p2;
    logic signed [9:0]  r_e2;
    logic               r_z2;
    logic [30:0]        r_xh2;

    // Stage 3 / output registers
    logic               r_ready;
    logic [30:0]        r_float_out;
    logic [30:0]        r_float_out_delay;

    logic signed [9:0]  w_e1;
    logic               w_z1;
    logic [25:0]        w_p_hi;
    logic               w_hi;
    logic [22:0]        w_f_pre;
    logic               w_guard;
    logic [23:0]        w_rnd;
    logic signed [9:0]  w_e3;
    logic [22:0]        w_f3;
    logic [30:0]        w_packed;

    // Clamp to zero / infinity or pack exponent and fraction.
    function automatic logic [30:0] pack_result(input logic z, input logic signed [9:0] e,
                                                input logic [22:0] f);
        logic [30:0] res;
        if (z || (e <= 10'sd0)) begin
            res = 31'h00000000;
        end else if (e >= 10'sd255) begin
            res = 31'h7F800000;
        end else begin
            res = {e[7:0], f};
        end
        return res;
    endfunction

    assign w_e1 = 10'({2'b00, corr_in[30:23]} + {2'b00, y_in[30:23]} - 10'(EXP_BIAS));
    assign w_z1 = ZERO_ON_DENORM & ((corr_in[30:23] == 8'd0) | (y_in[30:23] == 8'd0));

    // Bits below p[22] never influence round-half-up, so they are dropped here.
    assign w_p_hi = 26'((48'(r_mc1) * 48'(r_my1)) >> 22);

    // Normalize, round half-up and handle the rounding carry-out.
    always_comb begin
        w_hi    = r_p2[25];
        w_f_pre = 23'd0;
        w_guard = 1'b0;
        w_e3    = r_e2;
        w_f3    = 23'd0;
        if (w_hi) begin
            w_f_pre = r_p2[24:2];
            w_guard = r_p2[1];
            w_e3    = r_e2 + 10'sd1;
        end else begin
            w_f_pre = r_p2[23:1];
            w_guard = r_p2[0];
            w_e3    = r_e2;
        end
        w_rnd = {1'b0, w_f_pre} + {23'd0, w_guard};
        if (w_rnd[23]) begin
            w_f3 = 23'd0;
            w_e3 = w_e3 + 10'sd1;
        end else begin
            w_f3 = w_rnd[22:0];
        end
        w_packed = pack_result(r_z2, w_e3, w_f3);
    end

    // Valid chain: shifts every cycle, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_v1    <= valid;
            r_v2    <= r_v1;
            r_ready <= r_v2;
        end
    end

    // Stage 1: unpack operands; holds when no operand arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mc1 <= 24'd0;
            r_my1 <= 24'd0;
            r_e1  <= 10'sd0;
            r_z1  <= 1'b0;
            r_xh1 <= 31'd0;
        end else if (valid) begin
            r_mc1 <= {1'b1, corr_in[22:0]};
            r_my1 <= {1'b1, y_in[22:0]};
            r_e1  <= w_e1;
            r_z1  <= w_z1;
            r_xh1 <= xh_in;
        end else begin
            r_mc1 <= r_mc1;
            r_my1 <= r_my1;
            r_e1  <= r_e1;
            r_z1  <= r_z1;
            r_xh1 <= r_xh1;
        end
    end

    // Stage 2: mantissa product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p2  <= 26'd0;
            r_e2  <= 10'sd0;
            r_z2  <= 1'b0;
            r_xh2 <= 31'd0;
        end else if (r_v1) begin
            r_p2  <= w_p_hi;
            r_e2  <= r_e1;
            r_z2  <= r_z1;
            r_xh2 <= r_xh1;
        end else begin
            r_p2  <= r_p2;
            r_e2  <= r_e2;
            r_z2  <= r_z2;
            r_xh2 <= r_xh2;
        end
    end

    // Stage 3: outputs hold their last result between ready pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_float_out       <= 31'd0;
            r_float_out_delay <= 31'd0;
        end else if (r_v2) begin
            r_float_out       <= w_packed;
            r_float_out_delay <= r_xh2;
        end else begin
            r_float_out       <= r_float_out;
            r_float_out_delay <= r_float_out_delay;
        end
    end

    assign float_out       = r_float_out;
    assign float_out_delay = r_float_out_delay;
    assign ready           = r_ready;

endmodule

// File: tb/tb_fp_nr_mul_pipe.sv
// Directed bench for fp_nr_mul_pipe: latency, rounding, clamping, streaming order and mid-flight reset.
module tb_fp_nr_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [30:0] corr_in;
    logic [30:0] y_in;
    logic [30:0] xh_in;
    logic [30:0] float_out;
    logic [30:0] float_out_delay;
    logic        ready;

    int n_tests = 0;
    int n_fail  = 0;

    fp_nr_mul_pipe #(.EXP_BIAS(127), .ZERO_ON_DENORM(1'b1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid           (valid),
        .corr_in         (corr_in),
        .y_in            (y_in),
        .xh_in           (xh_in),
        .float_out       (float_out),
        .float_out_delay (float_out_delay),
        .ready           (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [30:0] c, input logic [30:0] y, input logic [30:0] x);
        valid   = v;
        corr_in = c;
        y_in    = y;
        xh_in   = x;
    endtask

    // One isolated operation: result must appear exactly 3 cycles later.
    task automatic run_one(input string tag, input logic [30:0] c, input logic [30:0] y,
                           input logic [30:0] x, input logic [30:0] exp);
        drive(1'b1, c, y, x);
        cyc();
        drive(1'b0, 31'd0, 31'd0, 31'd0);
        chk({tag, "_rdy1"}, {31'd0, ready}, 32'd0);
        cyc();
        chk({tag, "_rdy2"}, {31'd0, ready}, 32'd0);
        cyc();
        chk({tag, "_rdy3"}, {31'd0, ready}, 32'd1);
        chk({tag, "_out"}, {1'b0, float_out}, {1'b0, exp});
        chk({tag, "_dly"}, {1'b0, float_out_delay}, {1'b0, x});
        cyc();
        chk({tag, "_rdy4"}, {31'd0, ready}, 32'd0);
    endtask

    logic [30:0] s_c   [5];
    logic [30:0] s_y   [5];
    logic [30:0] s_x   [5];
    logic [30:0] s_exp [5];
    logic [5:0]  s_pat;
    int          s_in;
    int          s_out;
    logic        exp_rdy;

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 31'h3FC00000, 31'h3F800000, 31'h3F000000);
        cyc();
        cyc();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_out", {1'b0, float_out}, 32'd0);
        chk("rst_dly", {1'b0, float_out_delay}, 32'd0);
        drive(1'b0, 31'd0, 31'd0, 31'd0);
        rst_n = 1'b1;
        cyc();

        // Basic: 1.5 x 1.0
        run_one("basic", 31'h3FC00000, 31'h3F800000, 31'h3F000000, 31'h3FC00000);
        // Normalization
        run_one("n15x15", 31'h3FC00000, 31'h3FC00000, 31'h11111111, 31'h40100000);
        run_one("n1x2", 31'h3F800000, 31'h40000000, 31'h22222222, 31'h40000000);
        // Rounding
        run_one("rnd_up", 31'h3FC00000, 31'h3F800001, 31'h33333333, 31'h3FC00002);
        run_one("rnd_dn", 31'h3F800001, 31'h3F800001, 31'h44444444, 31'h3F800002);
        // Boundaries
        run_one("zero_y", 31'h3FC00000, 31'h00000000, 31'h55555555, 31'h00000000);
        run_one("sat_inf", 31'h7F7FFFFF, 31'h3FC00000, 31'h66666666, 31'h7F800000);
        run_one("e_zero", 31'h00800000, 31'h3F000000, 31'h77777777, 31'h00000000);

        // Streaming: valid pattern 1,1,1,1,0,1
        s_c[0] = 31'h3FC00000; s_y[0] = 31'h3F800000; s_x[0] = 31'h00000001; s_exp[0] = 31'h3FC00000;
        s_c[1] = 31'h3FC00000; s_y[1] = 31'h3FC00000; s_x[1] = 31'h00000002; s_exp[1] = 31'h40100000;
        s_c[2] = 31'h3F800000; s_y[2] = 31'h40000000; s_x[2] = 31'h00000003; s_exp[2] = 31'h40000000;
        s_c[3] = 31'h3FC00000; s_y[3] = 31'h3F800001; s_x[3] = 31'h00000004; s_exp[3] = 31'h3FC00002;
        s_c[4] = 31'h3F800001; s_y[4] = 31'h3F800001; s_x[4] = 31'h00000005; s_exp[4] = 31'h3F800002;
        s_pat = 6'b101111;
        s_in  = 0;
        s_out = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 6 && s_pat[i]) begin
                drive(1'b1, s_c[s_in], s_y[s_in], s_x[s_in]);
                s_in++;
            end else begin
                drive(1'b0, 31'd0, 31'd0, 31'd0);
            end
            exp_rdy = (i >= 3 && i <= 8) ? s_pat[i-3] : 1'b0;
            chk($sformatf("strm_rdy_c%0d", i), {31'd0, ready}, {31'd0, exp_rdy});
            if (exp_rdy && s_out < 5) begin
                chk($sformatf("strm_out_c%0d", i), {1'b0, float_out}, {1'b0, s_exp[s_out]});
                chk($sformatf("strm_dly_c%0d", i), {1'b0, float_out_delay}, {1'b0, s_x[s_out]});
                s_out++;
            end
            if (i == 7) begin
                chk("strm_hold_c7", {1'b0, float_out}, {1'b0, s_exp[3]});
            end
            cyc();
        end

        // Mid-flight reset: op captured, then reset discards it.
        drive(1'b1, 31'h3FC00000, 31'h3FC00000, 31'h12345678);
        cyc();
        drive(1'b0, 31'd0, 31'd0, 31'd0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("mrst_rdy_c%0d", i), {31'd0, ready}, 32'd0);
            chk($sformatf("mrst_out_c%0d", i), {1'b0, float_out}, 32'd0);
            chk($sformatf("mrst_dly_c%0d", i), {1'b0, float_out_delay}, 32'd0);
            cyc();
        end
        run_one("post_rst", 31'h3FC00000, 31'h3FC00000, 31'h0ABCDEF0, 31'h40100000);

        // Valid on the first edge with rst_n high enters normally.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        run_one("first_edge", 31'h3F800000, 31'h40000000, 31'h0000BEEF, 31'h40000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
